// File: rtl/bitbrick_seq_mac_if.sv
// Operand/result bundle for bitbrick_seq_mac; slave is the MAC, master is the
// producer/consumer pair around it.
interface bitbrick_seq_mac_if #(
  parameter int W     = 8,
  parameter int ACC_W = 32
);
  // Both sides use strict valid/ready: a transfer happens on a rising edge
  // where valid and ready are both high; a source keeps valid and its payload
  // stable until that edge, and ready never waits on valid.
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             sign_a;
  logic             sign_b;
  logic [1:0]       bits_sel;
  logic             acc_clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;

  modport master (
    output in_valid, a, b, sign_a, sign_b, bits_sel, acc_clear, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, a, b, sign_a, sign_b, bits_sel, acc_clear, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/bitbrick_seq_mac.sv
// Temporally fused MAC: one 2-bit bitbrick product per cycle into a local accumulator.
// Optional build macro BITBRICK_SEQ_SAT_EN makes every accumulate step saturate.
module bitbrick_seq_mac #(
  parameter int W     = 8,
  parameter int ACC_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  bitbrick_seq_mac_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] D_MAX = 4'(W / 2);

  state_t           state;
  logic [W-1:0]     a_r;
  logic [W-1:0]     b_r;
  logic             sa_r;
  logic             sb_r;
  logic [2:0]       d_last_r;
  logic [2:0]       i_r;
  logic [2:0]       j_r;
  logic [ACC_W-1:0] acc_r;
  logic             out_valid_r;

  logic [3:0]        d_req;
  logic [3:0]        d_cap;
  logic [1:0]        a_dig;
  logic [1:0]        b_dig;
  logic signed [2:0] a_ext;
  logic signed [2:0] b_ext;
  logic signed [5:0] prod;
  logic [4:0]        shamt;
  logic [ACC_W-1:0]  addend;
  logic [ACC_W-1:0]  acc_next;

  // Digit count D = N/2, with precisions wider than the operand port clamped.
  always_comb begin
    d_req = 4'd1 << bus.bits_sel;
    d_cap = (d_req > D_MAX) ? D_MAX : d_req;
  end

  always_comb begin
    a_dig = 2'b00;
    b_dig = 2'b00;
    for (int k = 0; k < W / 2; k++) begin
      if (i_r == 3'(k)) a_dig = a_r[2*k +: 2];
      if (j_r == 3'(k)) b_dig = b_r[2*k +: 2];
    end
  end

  // Only the top digit of a signed operand carries the sign; lower digits are magnitudes.
  assign a_ext  = {sa_r & (i_r == d_last_r) & a_dig[1], a_dig};
  assign b_ext  = {sb_r & (j_r == d_last_r) & b_dig[1], b_dig};
  assign prod   = a_ext * b_ext;
  assign shamt  = {1'b0, i_r, 1'b0} + {1'b0, j_r, 1'b0};
  assign addend = {{(ACC_W-6){prod[5]}}, prod} << shamt;

`ifdef BITBRICK_SEQ_SAT_EN
  logic [ACC_W:0] sum_ext;
  always_comb begin
    sum_ext = {acc_r[ACC_W-1], acc_r} + {addend[ACC_W-1], addend};
    if (sum_ext[ACC_W] != sum_ext[ACC_W-1])
      acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next = sum_ext[ACC_W-1:0];
  end
`else
  assign acc_next = acc_r + addend;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      a_r         <= '0;
      b_r         <= '0;
      sa_r        <= 1'b0;
      sb_r        <= 1'b0;
      d_last_r    <= '0;
      i_r         <= '0;
      j_r         <= '0;
      acc_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_r      <= bus.a;
            b_r      <= bus.b;
            sa_r     <= bus.sign_a;
            sb_r     <= bus.sign_b;
            d_last_r <= 3'(d_cap - 4'd1);
            i_r      <= '0;
            j_r      <= '0;
            if (bus.acc_clear) acc_r <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc_r <= acc_next;
          if (j_r == d_last_r) begin
            j_r <= '0;
            if (i_r == d_last_r) begin
              i_r         <= '0;
              out_valid_r <= 1'b1;
              state       <= DONE;
            end else begin
              i_r <= i_r + 3'd1;
            end
          end else begin
            j_r <= j_r + 3'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.result    = acc_r;
  assign dbg_state     = state;

endmodule

// File: tb/tb_bitbrick_seq_mac.sv
// Directed bench for bitbrick_seq_mac: latency, signed digits, accumulation,
// backpressure, reset abort and the 16-bit accumulator wrap/saturate case.
module tb_bitbrick_seq_mac;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  bitbrick_seq_mac_if #(.W(8), .ACC_W(32)) bus();
  bitbrick_seq_mac_if #(.W(8), .ACC_W(16)) bus16();
  logic [1:0] dbg_state;
  logic [1:0] dbg_state16;

  bitbrick_seq_mac #(.W(8), .ACC_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave), .dbg_state(dbg_state)
  );

  bitbrick_seq_mac #(.W(8), .ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .bus(bus16.slave), .dbg_state(dbg_state16)
  );

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sa,
                          input logic sb, input logic [1:0] bsel, input logic clr);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.sign_a = sa; bus.sign_b = sb;
    bus.bits_sel = bsel; bus.acc_clear = clr; bus.in_valid = 1'b1;
    @(posedge clk);
  endtask

  // Cycles from the accept edge until out_valid is seen; -1 when the budget expires.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic finish_op();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_n2();
    int lat;
    start_op(8'h02, 8'h03, 1'b1, 1'b0, 2'd0, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL n2_latency: got %0d expected 2", lat); end
    checks++;
    if (bus.result !== 32'hFFFF_FFFA) begin errors++; $display("FAIL n2_result: got %h expected fffffffa", bus.result); end
    finish_op();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL n2_handshake: out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_n8();
    int lat;
    start_op(8'h80, 8'h7F, 1'b1, 1'b1, 2'd2, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL n8_latency: got %0d expected 17", lat); end
    checks++;
    if (bus.result !== 32'(-16256)) begin errors++; $display("FAIL n8_result: got %0d expected -16256", $signed(bus.result)); end
    finish_op();
  endtask

  task automatic test_accumulate();
    int lat;
    logic [31:0] exp;
    exp_q.push_back(32'd15);
    exp_q.push_back(32'd13);
    start_op(8'h03, 8'h05, 1'b0, 1'b0, 2'd1, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL n4_latency: got %0d expected 5", lat); end
    exp = exp_q.pop_front();
    checks++;
    if (bus.result !== exp) begin errors++; $display("FAIL acc_first: got %0d expected %0d", $signed(bus.result), exp); end
    finish_op();
    start_op(8'h0F, 8'h02, 1'b1, 1'b1, 2'd1, 1'b0);
    wait_done(lat);
    exp = exp_q.pop_front();
    checks++;
    if (bus.result !== exp) begin errors++; $display("FAIL acc_second: got %0d expected %0d", $signed(bus.result), exp); end
    finish_op();
  endtask

  task automatic test_ignore_upper();
    int lat;
    start_op(8'hA5, 8'h3E, 1'b0, 1'b0, 2'd1, 1'b1);
    wait_done(lat);
    checks++;
    if (bus.result !== 32'd70) begin errors++; $display("FAIL upper_bits: got %0d expected 70", $signed(bus.result)); end
    finish_op();
  endtask

  task automatic test_clamp();
    int lat;
    start_op(8'hFF, 8'h03, 1'b1, 1'b1, 2'd3, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL clamp_latency: got %0d expected 17", lat); end
    checks++;
    if (bus.result !== 32'(-3)) begin errors++; $display("FAIL clamp_result: got %0d expected -3", $signed(bus.result)); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat;
    start_op(8'h01, 8'h01, 1'b0, 1'b0, 2'd0, 1'b1);
    wait_done(lat);
    bus.a = 8'h02; bus.b = 8'h02; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
    bus.bits_sel = 2'd0; bus.acc_clear = 1'b1; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.result !== 32'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b result=%0d expected 1/0/1",
                 c, bus.out_valid, bus.in_ready, bus.result);
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 32'd1) begin
      errors++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b result=%0d expected 1/0/1",
               bus.in_ready, bus.out_valid, bus.result);
    end
    @(posedge clk);
    wait_done(lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_next_latency: got %0d expected 2", lat); end
    checks++;
    if (bus.result !== 32'd4) begin errors++; $display("FAIL bp_next_result: got %0d expected 4", $signed(bus.result)); end
    finish_op();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    start_op(8'h7F, 8'h7F, 1'b1, 1'b1, 2'd2, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_state: out_valid=%b result=%0d in_ready=%b expected 0/0/1",
               bus.out_valid, bus.result, bus.in_ready);
    end
    start_op(8'h01, 8'h01, 1'b0, 1'b0, 2'd0, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 2 || bus.result !== 32'd1) begin
      errors++; $display("FAIL abort_next: latency=%0d result=%0d expected 2/1", lat, bus.result);
    end
    finish_op();
  endtask

  task automatic test_sat();
    logic [15:0] exp16;
    logic [15:0] got16;
    int done_cnt;
`ifdef BITBRICK_SEQ_SAT_EN
    exp16 = 16'd32767;
`else
    exp16 = 16'(-17149);
`endif
    got16 = '0;
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus16.a = 8'h7F; bus16.b = 8'h7F; bus16.sign_a = 1'b1; bus16.sign_b = 1'b1;
      bus16.bits_sel = 2'd2; bus16.acc_clear = (k == 0); bus16.in_valid = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        bus16.in_valid = 1'b0;
        if (bus16.out_valid) begin
          got16 = bus16.result;
          done_cnt++;
          break;
        end
      end
      bus16.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.out_ready = 1'b0;
    end
    checks++;
    if (done_cnt !== 3) begin errors++; $display("FAIL acc16_ops: got %0d completions expected 3", done_cnt); end
    checks++;
    if (got16 !== exp16) begin errors++; $display("FAIL acc16_result: got %0d expected %0d", $signed(got16), $signed(exp16)); end
  endtask

  initial begin
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sign_a = 1'b0; bus.sign_b = 1'b0;
    bus.bits_sel = 2'd0; bus.acc_clear = 1'b0; bus.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.sign_a = 1'b0; bus16.sign_b = 1'b0;
    bus16.bits_sel = 2'd0; bus16.acc_clear = 1'b0; bus16.out_ready = 1'b0;
    test_reset();
    test_n2();
    test_n8();
    test_accumulate();
    test_ignore_upper();
    test_clamp();
    test_backpressure();
    test_reset_mid_run();
    test_sat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
